// File: rtl/dp_ram_batch_pkg.sv
// Register map, state encoding and STATUS packing shared by the
// dual-port RAM batch controller and its helpers.
package dp_ram_batch_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_MARK_BUSY  = 4'd1,
        S_RD_ADDR    = 4'd2,
        S_RD_CAP     = 4'd3,
        S_MUL_WAIT   = 4'd4,
        S_WR_RESULT  = 4'd5,
        S_SET_STATUS = 4'd6,
        S_WAIT_CLEAR = 4'd7,
        S_CLEAR      = 4'd8
    } state_t;

    localparam int CTRL_OFS = 0;
    localparam int STAT_OFS = 1;

    localparam int CTL_START  = 0;
    localparam int CTL_CNT_LO = 4;
    localparam int CTL_CNT_HI = 7;

    localparam int ST_DONE    = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_TO_ERR  = 2;
    localparam int ST_CNT_ERR = 3;
    localparam int ST_CMP_LO  = 8;
    localparam int ST_CMP_HI  = 15;

    function automatic logic [15:0] status_word(
        input logic [7:0] cmp,
        input logic       to_err,
        input logic       cnt_err,
        input logic       busy,
        input logic       fin
    );
        logic [15:0] w;
        w = '0;
        w[ST_CMP_HI:ST_CMP_LO] = cmp;
        w[ST_CNT_ERR] = cnt_err;
        w[ST_TO_ERR]  = to_err;
        w[ST_BUSY]    = busy;
        w[ST_DONE]    = fin;
        return w;
    endfunction

endpackage

// File: rtl/dp_ram_batch_controller_timeout.sv
// Watchdog for the multiplier handshake: flags expiry once the enable
// has been held for TIMEOUT_CYC cycles since the last clear.
module batch_timeout_counter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dp_ram_batch_controller.sv
// Batch controller: polls CONTROL, runs up to N_CH operand words through
// the external multiplier, writes each product and a final STATUS back.
module dp_ram_batch_controller
    import dp_ram_batch_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int N_CH        = 4,
    parameter int DIN_BASE    = 4,
    parameter int DOUT_BASE   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                CLK,
    input  logic                rst,
    output logic [ADDR_W-1:0]   ADDR,
    output logic                WRITE_F,
    output logic [DATA_W-1:0]   WRITE_DATA,
    input  logic [DATA_W-1:0]   READ_DATA,
    output logic [DATA_W/8-1:0] BYTE_ENABLE,
    output logic [OP_W-1:0]     A,
    output logic [OP_W-1:0]     B,
    input  logic                done,
    input  logic [2*OP_W-1:0]   Y,
    output logic                ena,
    output logic [3:0]          state_o
);
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_OFS);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_OFS);
    localparam logic [ADDR_W-1:0] DIN_A  = ADDR_W'(DIN_BASE);
    localparam logic [ADDR_W-1:0] DOUT_A = ADDR_W'(DOUT_BASE);
    localparam logic [3:0]        NCH4   = 4'(N_CH);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cmp_q, cmp_d;
    logic              to_err_q, to_err_d;
    logic              cnt_err_q, cnt_err_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*OP_W-1:0] y_q, y_d;
    logic              ena_q, ena_d;
    logic              ctl_vld_q, ctl_vld_d;
    logic              tmo_clr, tmo_en, tmo_exp;
    logic [3:0]        req_cnt;
    logic              unused_rd;

    assign unused_rd = ^READ_DATA;

    assign A       = a_q;
    assign B       = b_q;
    assign ena     = ena_q;
    assign state_o = state_q;

    assign BYTE_ENABLE = {(DATA_W/8){WRITE_F}};

    assign req_cnt = (READ_DATA[CTL_CNT_HI:CTL_CNT_LO] == 4'd0)
                   ? NCH4 : READ_DATA[CTL_CNT_HI:CTL_CNT_LO];

    // READ_DATA is only a CONTROL value if last cycle was a CONTROL read.
    assign ctl_vld_d = (ADDR == CTRL_A) && !WRITE_F;

    batch_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk_i    (CLK),
        .rst_i    (rst),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_exp)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cmp_d      = cmp_q;
        to_err_d   = to_err_q;
        cnt_err_d  = cnt_err_q;
        a_d        = a_q;
        b_d        = b_q;
        y_d        = y_q;
        ena_d      = ena_q;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        ADDR       = CTRL_A;
        WRITE_F    = 1'b0;
        WRITE_DATA = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ctl_vld_q && READ_DATA[CTL_START]) begin
                    cnt_d     = req_cnt;
                    idx_d     = '0;
                    cmp_d     = '0;
                    to_err_d  = 1'b0;
                    cnt_err_d = req_cnt > NCH4;
                    state_d   = (req_cnt > NCH4) ? S_SET_STATUS : S_MARK_BUSY;
                end
            end
            S_MARK_BUSY: begin
                ADDR       = STAT_A;
                WRITE_F    = 1'b1;
                WRITE_DATA = DATA_W'(status_word(8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
                idx_d      = '0;
                state_d    = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                ADDR    = DIN_A + ADDR_W'(idx_q);
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                ADDR    = DIN_A + ADDR_W'(idx_q);
                a_d     = READ_DATA[OP_W-1:0];
                b_d     = READ_DATA[2*OP_W-1:OP_W];
                ena_d   = 1'b1;
                tmo_clr = 1'b1;
                state_d = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                tmo_en = 1'b1;
                if (done) begin
                    y_d     = Y;
                    ena_d   = 1'b0;
                    state_d = S_WR_RESULT;
                end else if (tmo_exp) begin
                    ena_d    = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = S_SET_STATUS;
                end
            end
            S_WR_RESULT: begin
                ADDR       = DOUT_A + ADDR_W'(idx_q);
                WRITE_F    = 1'b1;
                WRITE_DATA = DATA_W'(y_q);
                cmp_d      = cmp_q + 8'd1;
                if (idx_q == cnt_q - 4'd1) begin
                    state_d = S_SET_STATUS;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_RD_ADDR;
                end
            end
            S_SET_STATUS: begin
                ADDR       = STAT_A;
                WRITE_F    = 1'b1;
                WRITE_DATA = DATA_W'(status_word(cmp_q, to_err_q,
                                                 cnt_err_q, 1'b0, 1'b1));
                state_d    = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                if (ctl_vld_q && !READ_DATA[CTL_START]) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ADDR    = STAT_A;
                WRITE_F = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            cmp_q     <= '0;
            to_err_q  <= 1'b0;
            cnt_err_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            y_q       <= '0;
            ena_q     <= 1'b0;
            ctl_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            to_err_q  <= to_err_d;
            cnt_err_q <= cnt_err_d;
            a_q       <= a_d;
            b_q       <= b_d;
            y_q       <= y_d;
            ena_q     <= ena_d;
            ctl_vld_q <= ctl_vld_d;
        end
    end

endmodule

// File: tb/tb_dp_ram_batch_controller.sv
// Directed bench: RAM and multiplier models, a scoreboard of required
// RAM writes derived from the register map, plus literal result checks.
module tb_dp_ram_batch_controller;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  ADDR;
    logic        WRITE_F;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic [3:0]  BYTE_ENABLE;
    logic [3:0]  A, B;
    logic        done;
    logic [7:0]  Y;
    logic        ena;
    logic [3:0]  state_o;

    dp_ram_batch_controller dut (
        .CLK        (CLK),
        .rst        (rst),
        .ADDR       (ADDR),
        .WRITE_F    (WRITE_F),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BYTE_ENABLE(BYTE_ENABLE),
        .A          (A),
        .B          (B),
        .done       (done),
        .Y          (Y),
        .ena        (ena),
        .state_o    (state_o)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [16];
    logic        host_we = 1'b0;
    logic [3:0]  host_addr = 4'd0;
    logic [31:0] host_data = 32'd0;

    always @(posedge CLK) begin
        READ_DATA <= mem[ADDR];
        if (WRITE_F) mem[ADDR] <= WRITE_DATA;
        if (host_we) mem[host_addr] <= host_data;
    end

    // Multiplier: done appears L cycles after ena is first sampled high.
    int mul_lat = 2;
    bit mul_never = 1'b0;
    int mul_cnt = 0;
    always @(posedge CLK) mul_cnt <= ena ? mul_cnt + 1 : 0;
    assign done = ena && !mul_never && (mul_cnt == mul_lat);
    assign Y = {4'b0, A} * {4'b0, B};

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ena_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [3:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Required write sequence for one batch, from the register map rules.
    task automatic model_batch(input logic [31:0] ctrl);
        int n;
        logic [31:0] w;
        n = (ctrl[7:4] == 4'd0) ? 4 : int'(ctrl[7:4]);
        if (n > 4) begin
            push_w(4'd1, 32'h0000_0009);
            return;
        end
        push_w(4'd1, 32'h0000_0002);
        for (int k = 0; k < n; k++) begin
            if (mul_never) begin
                push_w(4'd1, 32'(k << 8) | 32'h5);
                return;
            end
            w = mem[4 + k];
            push_w(4'(8 + k), 32'(w[3:0]) * 32'(w[7:4]));
        end
        push_w(4'd1, 32'(n << 8) | 32'h1);
    endtask

    initial begin
        wr_t w;
        forever begin
            @(negedge CLK);
            if (!rst) begin
                if (ena) ena_cyc++;
                chk("byte_enable", 32'(BYTE_ENABLE),
                    WRITE_F ? 32'hF : 32'h0);
                if (WRITE_F) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data 0x%08h, none required",
                                 ADDR, WRITE_DATA);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", 32'(ADDR), 32'(w.a));
                        chk("wr_data", WRITE_DATA, w.d);
                    end
                end else begin
                    chk("idle_wdata", WRITE_DATA, 32'd0);
                end
            end
        end
    end

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        host_addr = a;
        host_data = d;
        host_we   = 1'b1;
        @(posedge CLK);
        #1;
        host_we = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_batch(input string nm, input logic [31:0] ctrl,
                             input logic [31:0] st_lit, input int ena_lit,
                             input int hold);
        ena_cyc = 0;
        model_batch(ctrl);
        host_write(4'd0, ctrl);
        wait_drain({nm, "_drain"}, 2000);
        chk({nm, "_status"}, mem[1], st_lit);
        chk({nm, "_ena_cycles"}, 32'(ena_cyc), 32'(ena_lit));
        repeat (hold) @(negedge CLK);
        chk({nm, "_no_retrigger"}, 32'(ena_cyc), 32'(ena_lit));
        push_w(4'd1, 32'd0);
        host_write(4'd0, 32'd0);
        wait_drain({nm, "_clear_drain"}, 50);
        chk({nm, "_cleared_status"}, mem[1], 32'd0);
        chk({nm, "_idle_state"}, 32'(state_o), 32'd0);
        chk({nm, "_idle_addr"}, 32'(ADDR), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rises;
        bit  prev;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) host_write(4'(i), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_write_f", 32'(WRITE_F), 32'd0);
        chk("rst_wdata", WRITE_DATA, 32'd0);
        chk("rst_be", 32'(BYTE_ENABLE), 32'd0);
        chk("rst_ab", {24'd0, A, B}, 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        repeat (3) @(negedge CLK);

        host_write(4'd4, 32'h53);
        run_batch("single", 32'h11, 32'h0101, 3, 3);
        chk("single_dout0", mem[8], 32'h0F);

        host_write(4'd5, 32'hFF);
        host_write(4'd6, 32'h00);
        host_write(4'd7, 32'h21);
        run_batch("full", 32'h01, 32'h0401, 12, 20);
        chk("full_dout0", mem[8], 32'h0F);
        chk("full_dout1", mem[9], 32'hE1);
        chk("full_dout2", mem[10], 32'h00);
        chk("full_dout3", mem[11], 32'h02);

        run_batch("cnt_err", 32'h71, 32'h0009, 0, 3);

        host_write(4'd8, 32'hA5A5_A5A5);
        mul_never = 1'b1;
        run_batch("timeout", 32'h21, 32'h0005, 255, 3);
        chk("timeout_dout0", mem[8], 32'hA5A5_A5A5);
        mul_never = 1'b0;

        ena_cyc = 0;
        host_write(4'd10, 32'h5A5A_5A5A);
        model_batch(32'h01);
        host_write(4'd0, 32'h01);
        rises = 0;
        prev  = 1'b0;
        for (int k = 0; k < 500 && rises < 3; k++) begin
            @(negedge CLK);
            if (ena && !prev) rises++;
            prev = ena;
        end
        chk("rst_reached_ch2", 32'(rises), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_ena", 32'(ena), 32'd0);
        chk("arst_write_f", 32'(WRITE_F), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_addr", 32'(ADDR), 32'd0);
        exp_q.delete();
        host_write(4'd0, 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        repeat (10) @(negedge CLK);
        chk("arst_dout2_kept", mem[10], 32'h5A5A_5A5A);
        chk("arst_dout1", mem[9], 32'hE1);
        chk("arst_status_kept", mem[1], 32'h0002);
        chk("arst_idle", 32'(state_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_ram_batch_controller.md
Name: dp_ram_batch_controller

Overview:
- Parametrised successor of the single-operand dual-port RAM controller.
- Polls a CONTROL word written by the HPS into the shared dual-port RAM, then reads up to N_CH packed operand words.
- Drives each operand pair through the external multiplier via the ena/done handshake, writes each product back, and publishes STATUS.
- Adds batch count, per-operation timeout, error reporting and a completed-channel counter.

Parameters:
- ADDR_W, 4, RAM word-address width.
- DATA_W, 32, RAM data width.
- OP_W, 4, operand width. A = word[OP_W-1:0], B = word[2*OP_W-1:OP_W]. Requires 2*OP_W <= DATA_W.
- N_CH, 4, maximum operand words per batch. Range 1..4 with defaults.
- DIN_BASE, 4, word address of operand word 0.
- DOUT_BASE, 8, word address of result word 0.
- TIMEOUT_CYC, 255, maximum cycles ena may stay high without done.

Ports:
- CLK  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ADDR  out  ADDR_W  RAM word address.
- WRITE_F  out  1  RAM write strobe.
- WRITE_DATA  out  DATA_W  RAM write data.
- READ_DATA  in  DATA_W  RAM read data, valid 1 cycle after ADDR.
- BYTE_ENABLE  out  DATA_W/8  byte lanes, all ones when WRITE_F=1, else 0.
- A  out  OP_W  multiplier operand A.
- B  out  OP_W  multiplier operand B.
- done  in  1  multiplier result valid.
- Y  in  2*OP_W  multiplier product.
- ena  out  1  multiplier enable.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, immediate):
  - state=IDLE (encoding 0); ADDR=CONTROL(0); WRITE_F=0; WRITE_DATA=0; BYTE_ENABLE=0; A=B=0; ena=0; channel index and completed count 0; timeout counter 0.
  - Reset mid-batch abandons the batch with no further RAM writes; STATUS is left as last written.
- Register map: CONTROL=0, STATUS=1, DIN_BASE+i, DOUT_BASE+i.
  - CONTROL[0]=start. CONTROL[7:4]=count; 0 means N_CH.
  - STATUS[0]=done, [1]=busy, [2]=timeout error, [3]=count error, [15:8]=channels completed, others 0.
- No output is ever X; don't-care slots drive 0.
- States and transitions:
  - IDLE: ADDR=CONTROL, reads continuously. Sampling READ_DATA[0]=1 latches count, then:
    - count>N_CH -> SET_STATUS with count error.
    - otherwise -> MARK_BUSY.
  - MARK_BUSY: write STATUS=0x2; i=0 -> RD_ADDR.
  - RD_ADDR: ADDR=DIN_BASE+i -> RD_CAP.
  - RD_CAP: latch A,B from READ_DATA; ena<=1; clear timeout counter -> MUL_WAIT.
  - MUL_WAIT: ena held at 1; A/B stable.
    - done=1 -> latch Y, ena<=0 -> WR_RESULT.
    - counter reaches TIMEOUT_CYC first -> ena<=0, set timeout error -> SET_STATUS.
    - done and timeout in the same cycle: done wins.
  - WR_RESULT: WRITE_F=1, ADDR=DOUT_BASE+i, WRITE_DATA=zero-extended Y; completed++.
    - i==count-1 -> SET_STATUS.
    - else i++ -> RD_ADDR.
  - SET_STATUS: write STATUS = {completed, errors, busy=0, done=1} -> WAIT_CLEAR.
  - WAIT_CLEAR: ADDR=CONTROL; stays while start=1. Start reading 0 -> CLEAR.
    - A start still high never retriggers a batch.
  - CLEAR: write STATUS=0 -> IDLE.
- Timing:
  - Per-channel overhead: 3 cycles plus multiplier latency.
  - Batch of n channels with multiplier latency L: start seen -> final STATUS write = 1 + n*(3+L) + 1 cycles.
- Multiplier contract: ena is only deasserted in the cycle after done or timeout. done sampled while ena=0 is ignored.
- Width rule: Y of 2*OP_W bits is zero-extended into DATA_W; no truncation is permitted (2*OP_W <= DATA_W).

Decomposition:
- Package dp_ram_batch_pkg holds:
  - state enum (4-bit);
  - CONTROL/STATUS offsets;
  - STATUS bit positions and the completed-field slice;
  - CONTROL start bit and count slice.
- One sub-module, batch_timeout_counter: clear/enable inputs, expired output, parametrised by TIMEOUT_CYC.

Test Plan:
- Single channel: DIN[4]=0x53, CONTROL=0x11, multiplier L=2 -> RAM[8]=0x0F; STATUS=0x0101; ena high exactly 3 cycles.
- Full batch: DIN[4..7]=0x53,0xFF,0x00,0x21, CONTROL=0x01 -> RAM[8..11]=0x0F,0xE1,0x00,0x02; STATUS=0x0401.
- Count error: CONTROL=0x71 with N_CH=4 -> no DOUT writes, ena never high, STATUS=0x0009.
- Timeout: multiplier never asserts done, CONTROL=0x21 -> ena drops after 255 cycles, STATUS=0x0005, RAM[8] untouched.
- Handshake: start held high 20 cycles after STATUS done -> no second batch. Start cleared -> STATUS=0, back in IDLE, ADDR=0.
- Async reset during MUL_WAIT of channel 2 -> ena=0 and WRITE_F=0 before the next CLK edge, state_o=0, no DOUT[10] write.
